// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and default parameter constants for the
//               multi-stage pipeline stall/flush controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Reason the pipeline is held or cleared in the current cycle
    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_FLUSH    = 3'd1,
        CAUSE_ICACHE   = 3'd2,
        CAUSE_MEM      = 3'd3,
        CAUSE_EX       = 3'd4,
        CAUSE_CP0      = 3'd5,
        CAUSE_LOAD_USE = 3'd6
    } stall_cause_e;

    // Default parameter values
    localparam int c_NUM_STAGES_DEF = 5;
    localparam int c_ID_EX_IDX_DEF  = 2;
    localparam int c_NUM_SRC_DEF    = 4;
    localparam int c_REG_W_DEF      = 5;
    localparam int c_WDOG_W_DEF     = 10;
    localparam int c_CNT_W_DEF      = 64;

    // First and last stall cause that owns a performance counter
    localparam int c_CAUSE_FIRST = 1;
    localparam int c_CAUSE_LAST  = 6;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_multi_hazard_cmp.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_cmp
// Description : NUM_SRC-way destination compare. Flags a hit when the check
//               is enabled, the destination is not register 0, and any valid
//               source slot names the destination. Purely combinational so it
//               can be shared with the slave-issue checker.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_cmp #(
    parameter int NUM_SRC = 4,
    parameter int REG_W   = 5
) (
    input  logic                     i_chk_en,
    input  logic [REG_W-1:0]         i_dest,
    input  logic [NUM_SRC*REG_W-1:0] i_src,
    input  logic [NUM_SRC-1:0]       i_src_valid,
    output logic                     o_hit
);

    logic [NUM_SRC-1:0] w_match;

    // Per-slot equality against the producing destination
    generate
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
            assign w_match[k] = i_src_valid[k] && (i_src[k*REG_W +: REG_W] == i_dest);
        end
    endgenerate

    // Register 0 is hard-wired zero and never creates a dependency
    assign o_hit = i_chk_en && (i_dest != '0) && (|w_match);

endmodule : pipe_hazard_cmp
`default_nettype wire

// File: rtl/pipe_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_multi
// Description : Priority stall/flush controller for an N-stage in-order
//               dual-issue pipeline. Produces per-register enable and flush
//               vectors, defers exception flushes across icache/memory
//               stalls, and runs a sticky stall watchdog.
//               Optional feature macro: PIPE_CTRL_PERF_CNT_EN adds a
//               per-cause performance counter bank (i_perf_sel/o_perf_data).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_multi
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = c_NUM_STAGES_DEF,
    parameter int ID_EX_IDX  = c_ID_EX_IDX_DEF,
    parameter int NUM_SRC    = c_NUM_SRC_DEF,
    parameter int REG_W      = c_REG_W_DEF,
    parameter int WDOG_W     = c_WDOG_W_DEF,
    parameter int CNT_W      = c_CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_icache_stall,
    input  logic                     i_ex_stall,
    input  logic                     i_mem_stall,
    input  logic                     i_exp_detect,
    input  logic                     i_id_branch_taken,
    input  logic                     i_fifo_full,
    input  logic                     i_id_ex_is_load,
    input  logic                     i_id_ex_is_mfc0,
    input  logic                     i_ex_mem_cp0_wen,
    input  logic [REG_W-1:0]         i_id_ex_wb_dest,
    input  logic [NUM_SRC*REG_W-1:0] i_id_src,
    input  logic [NUM_SRC-1:0]       i_id_src_valid,
`ifdef PIPE_CTRL_PERF_CNT_EN
    input  logic [2:0]               i_perf_sel,
    output logic [CNT_W-1:0]         o_perf_data,
`endif
    output logic [NUM_STAGES-1:0]    o_en,
    output logic [NUM_STAGES-1:0]    o_flush,
    output stall_cause_e             o_stall_cause,
    output logic                     o_stall_timeout
);

    logic                  r_flush_pending;
    logic [WDOG_W-1:0]     r_wdog;
    logic                  r_stall_timeout;

    logic                  w_load_use;
    logic [NUM_STAGES-1:0] w_en;
    logic [NUM_STAGES-1:0] w_en_final;
    logic [NUM_STAGES-1:0] w_flush;
    stall_cause_e          w_cause;
    logic                  w_set_pend;
    logic                  w_clr_pend;
    logic [WDOG_W-1:0]     w_wdog_nxt;

    pipe_hazard_cmp #(
        .NUM_SRC (NUM_SRC),
        .REG_W   (REG_W)
    ) u_hazard_cmp (
        .i_chk_en    (i_id_ex_is_load),
        .i_dest      (i_id_ex_wb_dest),
        .i_src       (i_id_src),
        .i_src_valid (i_id_src_valid),
        .o_hit       (w_load_use)
    );

    // Priority selection of enables, flushes and stall cause; first match wins
    always_comb begin
        w_en       = '1;
        w_flush    = '0;
        w_cause    = CAUSE_NONE;
        w_set_pend = 1'b0;
        w_clr_pend = 1'b0;
        if ((i_exp_detect || r_flush_pending) && !i_icache_stall && !i_mem_stall) begin
            // Clear every interior register; PC and writeback keep running
            for (int i = 1; i < NUM_STAGES-1; i++) begin
                w_flush[i] = 1'b1;
            end
            w_clr_pend = 1'b1;
            w_cause    = CAUSE_FLUSH;
        end else if (i_icache_stall && (i_mem_stall || i_exp_detect)) begin
            w_en       = '0;
            w_set_pend = i_exp_detect;
            w_cause    = CAUSE_ICACHE;
        end else if (i_icache_stall) begin
            // Only writeback drains while fetch is waiting
            w_en             = '0;
            w_en[NUM_STAGES-1] = 1'b1;
            w_cause          = CAUSE_ICACHE;
        end else if (i_mem_stall) begin
            // PC may advance unless a taken branch would be lost
            w_en       = '0;
            w_en[0]    = !i_id_branch_taken;
            w_set_pend = i_exp_detect;
            w_cause    = CAUSE_MEM;
        end else if (i_ex_stall) begin
            w_en               = '0;
            w_en[0]            = 1'b1;
            w_en[NUM_STAGES-1] = 1'b1;
            w_cause            = CAUSE_EX;
        end else if ((i_id_ex_is_mfc0 && i_ex_mem_cp0_wen) || w_load_use) begin
            // Hold front end through ID/EX and push a bubble into the next register
            for (int i = 1; i <= ID_EX_IDX; i++) begin
                w_en[i] = 1'b0;
            end
            w_flush[ID_EX_IDX+1] = 1'b1;
            w_cause = (i_id_ex_is_mfc0 && i_ex_mem_cp0_wen) ? CAUSE_CP0 : CAUSE_LOAD_USE;
        end
    end

    // A full fetch queue always blocks the PC register
    assign w_en_final = {w_en[NUM_STAGES-1:1], w_en[0] & ~i_fifo_full};

    // Watchdog counts cycles in which writeback is frozen, saturating at all-ones
    always_comb begin
        w_wdog_nxt = '0;
        if (!w_en_final[NUM_STAGES-1]) begin
            w_wdog_nxt = (r_wdog == '1) ? r_wdog : r_wdog + 1'b1;
        end
    end

    // Deferred-flush flag (set-dominant), watchdog counter and sticky timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_pending <= 1'b0;
            r_wdog          <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            if (w_set_pend) begin
                r_flush_pending <= 1'b1;
            end else if (w_clr_pend) begin
                r_flush_pending <= 1'b0;
            end
            r_wdog <= w_wdog_nxt;
            if (w_wdog_nxt == '1) begin
                r_stall_timeout <= 1'b1;
            end
        end
    end

    assign o_en            = w_en_final;
    assign o_flush         = w_flush;
    assign o_stall_cause   = w_cause;
    assign o_stall_timeout = r_stall_timeout;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_cnt [c_CAUSE_FIRST:c_CAUSE_LAST];

    // One wrapping counter per non-idle stall cause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = c_CAUSE_FIRST; c <= c_CAUSE_LAST; c++) begin
                r_perf_cnt[c] <= '0;
            end
        end else begin
            for (int c = c_CAUSE_FIRST; c <= c_CAUSE_LAST; c++) begin
                if (w_cause == stall_cause_e'(3'(c))) begin
                    r_perf_cnt[c] <= r_perf_cnt[c] + 1'b1;
                end
            end
        end
    end

    // Counter readback; NONE and unused codes read as zero
    always_comb begin
        o_perf_data = '0;
        for (int c = c_CAUSE_FIRST; c <= c_CAUSE_LAST; c++) begin
            if (i_perf_sel == 3'(c)) begin
                o_perf_data = r_perf_cnt[c];
            end
        end
    end
`endif

endmodule : pipe_ctrl_multi
`default_nettype wire

// File: tb/tb_pipe_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl_multi
// Description : Directed self-checking bench for pipe_ctrl_multi with a
//               queue-based scoreboard of expected en/flush/cause values.
//               Exercises PIPE_CTRL_PERF_CNT_EN readback when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_multi;
    import pipe_ctrl_pkg::*;

    localparam int NS = 5;
    localparam int NSRC = 4;
    localparam int RW = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               icache_stall = 0, ex_stall = 0, mem_stall = 0, exp_detect = 0;
    logic               id_branch_taken = 0, fifo_full = 0, id_ex_is_load = 0;
    logic               id_ex_is_mfc0 = 0, ex_mem_cp0_wen = 0;
    logic [RW-1:0]      id_ex_wb_dest = '0;
    logic [NSRC*RW-1:0] id_src = '0;
    logic [NSRC-1:0]    id_src_valid = '0;
    logic [NS-1:0]      en, flush;
    stall_cause_e       stall_cause;
    logic               stall_timeout;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [2:0]         perf_sel = '0;
    logic [63:0]        perf_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string         tag;
        logic [NS-1:0] en;
        logic [NS-1:0] flush;
        logic [2:0]    cause;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    pipe_ctrl_multi dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_icache_stall    (icache_stall),
        .i_ex_stall        (ex_stall),
        .i_mem_stall       (mem_stall),
        .i_exp_detect      (exp_detect),
        .i_id_branch_taken (id_branch_taken),
        .i_fifo_full       (fifo_full),
        .i_id_ex_is_load   (id_ex_is_load),
        .i_id_ex_is_mfc0   (id_ex_is_mfc0),
        .i_ex_mem_cp0_wen  (ex_mem_cp0_wen),
        .i_id_ex_wb_dest   (id_ex_wb_dest),
        .i_id_src          (id_src),
        .i_id_src_valid    (id_src_valid),
`ifdef PIPE_CTRL_PERF_CNT_EN
        .i_perf_sel        (perf_sel),
        .o_perf_data       (perf_data),
`endif
        .o_en              (en),
        .o_flush           (flush),
        .o_stall_cause     (stall_cause),
        .o_stall_timeout   (stall_timeout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push expectation, sample at negedge, pop and compare, then advance one clock
    task automatic cyc(input string tag, input logic [NS-1:0] e_en,
                       input logic [NS-1:0] e_fl, input logic [2:0] e_c);
        exp_t e;
        exp_t got;
        e.tag = tag; e.en = e_en; e.flush = e_fl; e.cause = e_c;
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        check({got.tag, ".en"},    64'(en),          64'(got.en));
        check({got.tag, ".flush"}, 64'(flush),       64'(got.flush));
        check({got.tag, ".cause"}, 64'(stall_cause), 64'(got.cause));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        icache_stall = 0; ex_stall = 0; mem_stall = 0; exp_detect = 0;
        id_branch_taken = 0; fifo_full = 0; id_ex_is_load = 0;
        id_ex_is_mfc0 = 0; ex_mem_cp0_wen = 0;
        id_ex_wb_dest = '0; id_src = '0; id_src_valid = '0;
    endtask

    initial begin
        // Reset state while rst_n is held low
        #12;
        cyc("reset", 5'b11111, 5'b00000, 3'd0);
        check("reset.timeout", 64'(stall_timeout), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle for 2000 cycles: no stall, no timeout
        repeat (2000) @(posedge clk);
        #1;
        cyc("idle", 5'b11111, 5'b00000, 3'd0);
        check("idle.timeout", 64'(stall_timeout), 64'd0);

        // Load-use on slot 2
        id_ex_is_load = 1; id_ex_wb_dest = 5'd7;
        id_src = 20'(5'd7) << 10; id_src_valid = 4'b0100;
        cyc("lduse", 5'b11001, 5'b01000, 3'd6);
        // Same slot but not valid
        id_src_valid = 4'b1011;
        cyc("lduse_inv", 5'b11111, 5'b00000, 3'd0);
        // Destination r0 never stalls
        id_ex_wb_dest = 5'd0; id_src = '0; id_src_valid = 4'b1111;
        cyc("lduse_r0", 5'b11111, 5'b00000, 3'd0);
        clear_inputs();

        // CP0 hazard
        id_ex_is_mfc0 = 1; ex_mem_cp0_wen = 1;
        cyc("cp0", 5'b11001, 5'b01000, 3'd5);
        clear_inputs();

        // Exception during icache stall is deferred until the stall drops
        icache_stall = 1; exp_detect = 1;
        cyc("ic_exp", 5'b00000, 5'b00000, 3'd2);
        exp_detect = 0;
        cyc("ic_hold1", 5'b10000, 5'b00000, 3'd2);
        cyc("ic_hold2", 5'b10000, 5'b00000, 3'd2);
        cyc("ic_hold3", 5'b10000, 5'b00000, 3'd2);
        icache_stall = 0;
        cyc("def_flush", 5'b11111, 5'b01110, 3'd1);
        cyc("post_flush", 5'b11111, 5'b00000, 3'd0);

        // Memory stall variants
        mem_stall = 1; id_branch_taken = 1;
        cyc("mem_br", 5'b00000, 5'b00000, 3'd3);
        id_branch_taken = 0; fifo_full = 1;
        cyc("mem_full", 5'b00000, 5'b00000, 3'd3);
        fifo_full = 0;
        cyc("mem", 5'b00001, 5'b00000, 3'd3);
        exp_detect = 1;
        cyc("mem_exp", 5'b00001, 5'b00000, 3'd3);
        exp_detect = 0; mem_stall = 0;
        cyc("mem_def_flush", 5'b11111, 5'b01110, 3'd1);
        clear_inputs();

        // EX stall, immediate exception flush, fifo_full alone
        ex_stall = 1;
        cyc("ex", 5'b10001, 5'b00000, 3'd4);
        ex_stall = 0; exp_detect = 1;
        cyc("exp_now", 5'b11111, 5'b01110, 3'd1);
        exp_detect = 0; fifo_full = 1;
        cyc("fifo_full", 5'b11110, 5'b00000, 3'd0);
        clear_inputs();

        // Watchdog: writeback frozen by icache+mem stall
        icache_stall = 1; mem_stall = 1;
        repeat (1022) @(posedge clk);
        #1;
        check("wdog_1022", 64'(stall_timeout), 64'd0);
        @(posedge clk); #1;
        check("wdog_1023", 64'(stall_timeout), 64'd1);
        clear_inputs();
        repeat (5) @(posedge clk);
        #1;
        check("wdog_sticky", 64'(stall_timeout), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("wdog_rst", 64'(stall_timeout), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef PIPE_CTRL_PERF_CNT_EN
        // Perf counters start from the reset above
        ex_stall = 1;
        repeat (5) @(posedge clk);
        #1;
        ex_stall = 0;
        id_ex_is_load = 1; id_ex_wb_dest = 5'd9;
        id_src = 20'(5'd9); id_src_valid = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        clear_inputs();
        @(posedge clk); #1;
        perf_sel = 3'd4; #1;
        check("perf_ex", perf_data, 64'd5);
        perf_sel = 3'd6; #1;
        check("perf_lduse", perf_data, 64'd3);
        perf_sel = 3'd0; #1;
        check("perf_none", perf_data, 64'd0);
        perf_sel = 3'd2; #1;
        check("perf_icache", perf_data, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pipe_ctrl_multi
`default_nettype wire
